// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11/DHT22 single-wire reader.
package dht_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StRelease,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StCheck
  } dht_state_e;

  localparam int unsigned FrameBits = 40;
  localparam int unsigned ByteBits  = 8;
  // Cycles ignored after release while the synchroniser still holds the host's own low.
  localparam int unsigned SyncGuard = 3;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/dht_sync2.sv
// Two-flop synchroniser for the asynchronous single-wire bus; idles high like the pulled-up line.
module dht_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 reader: issues the host start pulse, times the sensor reply and decodes a 40-bit frame.
module dht_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 1_000_000,
  parameter int unsigned POLL_MS        = 500,
  parameter int unsigned START_LOW_US   = 19000,
  parameter int unsigned BIT1_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US     = 200
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         dq,
  input  logic        start,
  input  logic        auto_en,
  output logic        busy,
  output logic [39:0] data,
  output logic        data_valid,
  output logic        crc_err,
  output logic        timeout_err
);

  localparam int unsigned PollCyc  = us_to_cycles(CLK_HZ, POLL_MS * 1000);
  localparam int unsigned StartCyc = us_to_cycles(CLK_HZ, START_LOW_US);
  localparam int unsigned Bit1Cyc  = us_to_cycles(CLK_HZ, BIT1_THRESH_US);
  localparam int unsigned ToCyc    = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned MaxA     = (PollCyc > StartCyc) ? PollCyc : StartCyc;
  localparam int unsigned MaxCyc   = (MaxA > ToCyc) ? MaxA : ToCyc;
  localparam int unsigned CntW     = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] PollLim  = CntW'(PollCyc - 1);
  localparam logic [CntW-1:0] StartLim = CntW'(StartCyc - 1);
  localparam logic [CntW-1:0] ToLim    = CntW'(ToCyc - 1);
  localparam logic [CntW-1:0] Bit1Lim  = CntW'(Bit1Cyc);
  localparam logic [CntW-1:0] GuardLim = CntW'(SyncGuard);
  localparam logic [CntW-1:0] CntMax   = '1;

  dht_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [FrameBits-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 crc_q, crc_d;
  logic                 to_q, to_d;
  logic                 dq_s;
  logic [ByteBits-1:0]  sum;

  dht_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dq),
    .q   (dq_s)
  );

  // Drive enable decodes straight from the state register so reset releases the bus at once.
  assign dq   = (state_q == StStartLow) ? 1'b0 : 1'bz;
  assign busy = (state_q != StIdle);
  assign sum  = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    crc_d     = 1'b0;
    to_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || (auto_en && (cnt_q >= PollLim))) begin
          state_d   = StStartLow;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StStartLow: if (cnt_q >= StartLim) state_d = StRelease;
      StRelease: begin
        if (!dq_s && (cnt_q >= GuardLim)) state_d = StRespLow;
        else if (cnt_q >= ToLim) to_d = 1'b1;
      end
      StRespLow: begin
        if (dq_s) state_d = StRespHigh;
        else if (cnt_q >= ToLim) to_d = 1'b1;
      end
      StRespHigh: begin
        if (!dq_s) state_d = StBitLow;
        else if (cnt_q >= ToLim) to_d = 1'b1;
      end
      StBitLow: begin
        if (dq_s) state_d = StBitHigh;
        else if (cnt_q >= ToLim) to_d = 1'b1;
      end
      StBitHigh: begin
        if (!dq_s) begin
          shift_d   = {shift_q[FrameBits-2:0], (cnt_q > Bit1Lim)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(FrameBits - 1)) ? StCheck : StBitLow;
        end else if (cnt_q >= ToLim) begin
          to_d = 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (sum == shift_q[7:0]) begin
          data_d = shift_q;
          dv_d   = 1'b1;
        end else begin
          crc_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_d) begin
      state_d   = StIdle;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
    // One shared timer: restarts on every state change, otherwise counts and saturates.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == CntMax) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      crc_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      crc_q     <= crc_d;
      to_q      <= to_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign crc_err     = crc_q;
  assign timeout_err = to_q;

endmodule

// File: doc/dht_reader.md
DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 Parameter CLK_HZ, default 1_000_000: clk frequency; every timing constant is derived from it as CLK_HZ/1_000_000 cycles per us.
REQ-002 Parameter POLL_MS, default 500: auto-mode interval from the end of one transaction to the next start.
REQ-003 Parameter START_LOW_US, default 19000: host start-pulse low time (18000+ for DHT11, 1000+ for DHT22).
REQ-004 Parameter BIT1_THRESH_US, default 50: a bit-high pulse longer than this decodes as 1.
REQ-005 Parameter TIMEOUT_US, default 200: maximum time in any sensor-driven wait state.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 dq  inout  1  single-wire bus; driven 0 when the internal drive-enable is 1, otherwise high-Z (external pull-up).
REQ-009 start  input  1  one-cycle request for a single transaction; ignored while busy.
REQ-010 auto_en  input  1  when 1, a transaction starts POLL_MS after the previous one ends.
REQ-011 busy  output  1  high from start of the host pulse until DONE/ERR.
REQ-012 data  output  40  last good frame {hum_hi, hum_lo, tmp_hi, tmp_lo, checksum}; updated only on checksum pass.
REQ-013 data_valid  output  1  one-cycle pulse when data is updated.
REQ-014 crc_err  output  1  one-cycle pulse on checksum mismatch.
REQ-015 timeout_err  output  1  one-cycle pulse on any timeout.

Function
REQ-016 dq is sampled through a 2-flop synchroniser; all decisions use the synchronised value dq_s.
REQ-017 The FSM states are IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-018 IDLE: on start=1, or on auto_en=1 with the poll counter at POLL_MS, go to START_LOW and set busy.
REQ-019 START_LOW: drive dq low for START_LOW_US, then release and go to RELEASE.
REQ-020 RELEASE: wait for dq_s=0 (sensor response), then go to RESP_LOW; timeout after TIMEOUT_US.
REQ-021 RESP_LOW waits for dq_s=1, then RESP_HIGH waits for dq_s=0, then go to BIT_LOW; each wait is time-limited.
REQ-022 BIT_LOW waits for dq_s=1, then BIT_HIGH counts high cycles until dq_s=0.
REQ-023 On leaving BIT_HIGH, shift in bit (count > BIT1_THRESH_US) MSB-first and increment the bit counter; after 40 bits go to CHECK, otherwise go to BIT_HIGH's successor BIT_LOW.
REQ-024 CHECK: compare (b4+b3+b2+b1) mod 256 with b0; on match, load data and pulse data_valid, otherwise pulse crc_err; return to IDLE and clear busy in the same cycle.
REQ-025 A timeout in any sensor wait state pulses timeout_err, releases dq, discards the partial frame, and returns to IDLE.
REQ-026 The poll counter restarts on every return to IDLE; if auto_en is deasserted, no further automatic starts occur.
REQ-027 If start and the auto trigger coincide, exactly one transaction starts.
REQ-028 The timing counter is wide enough for max(POLL_MS*1000, START_LOW_US) us at CLK_HZ, and it saturates rather than wrapping.
REQ-029 data_valid, crc_err and timeout_err are mutually exclusive in any cycle.

Reset
REQ-030 On rst: state=IDLE, drive-enable=0 (dq high-Z), busy=0, data=0, all pulses=0, counters=0, shift register=0, synchroniser=1.
REQ-031 Reset mid-transaction releases dq immediately (asynchronously) and produces no output pulse.

Structure
REQ-032 Package dht_pkg holds the state enum, the us-to-cycle conversion function, and the frame field width constants.
REQ-033 One sub-module, dht_sync2, implements the 2-flop synchroniser.

Verification
REQ-034 Sensor model sends frame 0x37_00_19_00_50 (CLK_HZ=1e6) on start -> busy asserted; data=0x3700190050 with a one-cycle data_valid; crc_err=0.
REQ-035 Frame 0x37_00_19_00_51 -> crc_err pulse; data keeps its previous value; no data_valid.
REQ-036 Sensor never responds after the start pulse -> timeout_err 200 us after release; dq high-Z; back to IDLE.
REQ-037 Sensor stops driving after bit 17 -> timeout_err pulse; the next transaction decodes correctly.
REQ-038 auto_en=1 with POLL_MS=2 -> starts spaced 2 ms after each transaction end; auto_en dropped -> no further starts.
REQ-039 rst asserted during BIT_HIGH -> dq immediately high-Z, all outputs 0; a start after reset produces a correct frame.
